// File: rtl/ext_irq_latch_if.sv
// ext_irq_latch_if
//   Bundles the external interrupt lines, the interrupt-stage service and
//   software-clear inputs, and the latched cause/pending outputs of
//   ext_irq_latch.
//   Modports:
//     master : the surrounding system (drives irq_in/jisr/mca/clr_*, reads results)
//     slave  : ext_irq_latch itself
//   Signals:
//     irq_in    [NUM_IRQ] raw asynchronous interrupt lines
//     jisr                 jump-to-ISR strobe, one cycle
//     mca       [23]       masked cause vector, external line i is mca[7+i]
//     clr_we               software clear strobe
//     clr_data  [NUM_IRQ]  write-1-to-clear mask
//     ca_part_1 [NUM_IRQ]  registered external cause bits
//     pending   [NUM_IRQ]  edge-pending register
//     lost      [NUM_IRQ]  sticky absorbed-edge flags (only with IRQ_LOST_EN)
interface ext_irq_latch_if #(
   parameter int unsigned NUM_IRQ = 16
);
   logic [NUM_IRQ-1:0] irq_in;
   logic               jisr;
   logic [22:0]        mca;
   logic               clr_we;
   logic [NUM_IRQ-1:0] clr_data;
   logic [NUM_IRQ-1:0] ca_part_1;
   logic [NUM_IRQ-1:0] pending;
`ifdef IRQ_LOST_EN
   logic [NUM_IRQ-1:0] lost;
`endif

`ifdef IRQ_LOST_EN
   modport master (
      output irq_in, jisr, mca, clr_we, clr_data,
      input  ca_part_1, pending, lost
   );
   modport slave (
      input  irq_in, jisr, mca, clr_we, clr_data,
      output ca_part_1, pending, lost
   );
`else
   modport master (
      output irq_in, jisr, mca, clr_we, clr_data,
      input  ca_part_1, pending
   );
   modport slave (
      input  irq_in, jisr, mca, clr_we, clr_data,
      output ca_part_1, pending
   );
`endif
endinterface

// File: rtl/ext_irq_latch.sv
// ext_irq_latch
//   Synchronizes the external interrupt lines, rising-edge latches or
//   level-passes each line (EDGE_MASK), and drives the external cause bits
//   ca_part_1 (landing at ca[22:7]). A pending edge is cleared when the
//   interrupt stage services it (jisr + lowest set mca[7+i], no internal
//   cause set) or when software writes 1 to it.
//   Optional build macro IRQ_LOST_EN adds sticky 'lost' flags recording a
//   rise that arrived while the line was already pending.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset, clears all state
//     bus  ext_irq_latch_if.slave (irq_in, jisr, mca, clr_we, clr_data,
//          ca_part_1, pending[, lost])
module ext_irq_latch #(
   parameter int unsigned        NUM_IRQ     = 16,
   parameter int unsigned        SYNC_STAGES = 2,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '1
) (
   input  logic            clk,
   input  logic            rst,
   ext_irq_latch_if.slave  bus
);

   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] s;
   logic [NUM_IRQ-1:0] prev_q;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] svc;
   logic               svc_found;
   logic [NUM_IRQ-1:0] clr_mask;
   logic [NUM_IRQ-1:0] keep;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] pending_d;
   logic [NUM_IRQ-1:0] ca_q;
   logic [NUM_IRQ-1:0] ca_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.irq_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~prev_q;

   // Only the lowest serviced external line is cleared; any internal cause
   // (mca[6:0]) outranks all external lines, so nothing external is serviced.
   always_comb begin
      svc       = '0;
      svc_found = 1'b0;
      if (bus.jisr && (bus.mca[6:0] == '0)) begin
         for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!svc_found && bus.mca[7+i]) begin
               svc[i]    = 1'b1;
               svc_found = 1'b1;
            end
         end
      end
   end

   assign clr_mask = bus.clr_we ? bus.clr_data : '0;
   assign keep     = pending_q & ~svc & ~clr_mask;

   // A fresh rise wins over any clear in the same cycle; level lines never pend.
   assign pending_d = EDGE_MASK & (rise | keep);
   assign ca_d      = (EDGE_MASK & pending_d) | (~EDGE_MASK & s);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q    <= '0;
         pending_q <= '0;
         ca_q      <= '0;
      end else begin
         prev_q    <= s;
         pending_q <= pending_d;
         ca_q      <= ca_d;
      end
   end

   assign bus.pending   = pending_q;
   assign bus.ca_part_1 = ca_q;

`ifdef IRQ_LOST_EN
   logic [NUM_IRQ-1:0] lost_q;
   logic [NUM_IRQ-1:0] lost_set;

   // An edge is lost only if the existing pending bit survives this cycle,
   // i.e. the new rise is genuinely absorbed rather than re-arming a cleared bit.
   assign lost_set = EDGE_MASK & rise & keep;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lost_q <= '0;
      end else begin
         lost_q <= lost_set | (lost_q & ~clr_mask);
      end
   end

   assign bus.lost = lost_q;
`endif

endmodule
